// File: rtl/pu_msp430_trace_ctrl.sv
// MSP430 instruction-trace capture: circular buffer of decode events with an
// arm/trigger/post-trigger sequencer and oldest-first valid/ready readout.
//
// state | meaning
// IDLE  | no capture, decodes ignored
// ARMED | pre-trigger capture, watching for PC match or force
// POST  | post-trigger capture, post_rem counts down remaining writes
// DONE  | capture frozen, draining oldest-first
module pu_msp430_trace_ctrl #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  mclk,
   input  logic                  reset_n,
   input  logic                  decode,
   input  logic [15:0]           pc,
   input  logic [15:0]           ir,
   input  logic                  irq_detect,
   input  logic                  arm,
   input  logic                  trig_en,
   input  logic [15:0]           trig_pc,
   input  logic                  trig_force,
   input  logic [DEPTH_LOG2:0]   post_cnt,
   input  logic                  rd_ready,
   output logic                  rd_valid,
   output logic [32:0]           rd_data,
   output logic                  rd_last,
   output logic [DEPTH_LOG2:0]   entries,
   output logic [2:0]            state,
   output logic                  triggered
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_POST  = 3'd2,
      ST_DONE  = 3'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     entries_q, entries_d;
   logic [DEPTH_LOG2:0]     post_cnt_q, post_cnt_d;
   logic [DEPTH_LOG2:0]     post_rem_q, post_rem_d;
   logic                    triggered_q, triggered_d;
   logic                    wr_en;
   logic                    trig_hit;
   logic [32:0]             trace_mem [DEPTH];

   assign trig_hit = (decode && trig_en && (pc == trig_pc)) || trig_force;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      entries_d   = entries_q;
      post_cnt_d  = post_cnt_q;
      post_rem_d  = post_rem_q;
      triggered_d = triggered_q;
      wr_en       = 1'b0;

      if (arm) begin
         // arm overrides any capture, trigger or transfer in the same cycle
         state_d     = ST_ARMED;
         wr_ptr_d    = '0;
         entries_d   = '0;
         triggered_d = 1'b0;
         post_cnt_d  = post_cnt;
      end else begin
         case (state_q)
            ST_ARMED, ST_POST: begin
               if (decode) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (entries_q != CNT_FULL) entries_d = entries_q + CNT_ONE;
               end
               if (state_q == ST_ARMED) begin
                  if (trig_hit) begin
                     triggered_d = 1'b1;
                     if (post_cnt_q == '0) begin
                        state_d = ST_DONE;
                     end else begin
                        state_d    = ST_POST;
                        post_rem_d = post_cnt_q;
                     end
                  end
               end else if (decode) begin
                  post_rem_d = post_rem_q - CNT_ONE;
                  if (post_rem_q == CNT_ONE) state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (entries_q == '0) begin
                  state_d     = ST_IDLE;
                  triggered_d = 1'b0;
               end else if (rd_ready) begin
                  rd_ptr_d  = rd_ptr_q + PTR_ONE;
                  entries_d = entries_q - CNT_ONE;
                  if (entries_q == CNT_ONE) begin
                     state_d     = ST_IDLE;
                     triggered_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end

      // a full buffer truncates entries to 0 here, so oldest is at wr_ptr
      if (state_d == ST_DONE && state_q != ST_DONE)
         rd_ptr_d = wr_ptr_d - entries_d[DEPTH_LOG2-1:0];
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         entries_q   <= '0;
         post_cnt_q  <= '0;
         post_rem_q  <= '0;
         triggered_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         entries_q   <= entries_d;
         post_cnt_q  <= post_cnt_d;
         post_rem_q  <= post_rem_d;
         triggered_q <= triggered_d;
      end
   end

   always_ff @(posedge mclk) begin
      if (wr_en) trace_mem[wr_ptr_q] <= {irq_detect, pc, ir};
   end

   assign rd_valid  = (state_q == ST_DONE) && (entries_q != '0);
   assign rd_last   = rd_valid && (entries_q == CNT_ONE);
   assign rd_data   = trace_mem[rd_ptr_q];
   assign entries   = entries_q;
   assign state     = state_q;
   assign triggered = triggered_q;

endmodule
